rr_decode_arbiter: RTL and testbench
====================================

// Module: rr_decode_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 4-way one-hot select resource between 4 requesters.
//  Holds a grant for as long as the owner keeps its request asserted.
//  Outputs both the 2-bit grant index and its decoded one-hot form.
//  Drives the select lines of a shared 4-way datapath (bus mux/enable fan-out).
// PARAMETERS
//  HOLD_MAX  15  max consecutive BUSY cycles per grant (used only when ARB_TIMEOUT_EN defined)
//  CNT_W     4   hold-counter width; must satisfy HOLD_MAX <= 2**CNT_W-1
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  asynchronous active-low reset
//  req        in   4  request per requester, level; bit i = requester i
//  gnt        out  4  one-hot grant, registered; 0 when no owner
//  gnt_idx    out  2  binary index of owner; valid only when gnt_valid=1
//  gnt_valid  out  1  1 while a grant is held
//  timeout    out  1  1-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN
// BEHAVIOUR
//  Reset (async, rst_n=0): gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0, timeout=0,
//   last=2'b11 (so req[0] has top priority first), hold_cnt=0, state=IDLE.
//  FSM states: IDLE, BUSY.
//  IDLE: if req!=0 -> search from (last+1) mod 4 upward with wrap; first set bit wins.
//   Next cycle: state=BUSY, gnt_idx=winner, gnt=1<<winner, gnt_valid=1. Grant latency = 1 clk.
//   req==0 -> stay IDLE, outputs 0.
//  BUSY: req[gnt_idx]=1 -> hold grant unchanged; other req bits are ignored.
//   req[gnt_idx]=0 -> next cycle gnt=0, gnt_valid=0, last=gnt_idx, state=IDLE.
//  No back-to-back grants: at least one IDLE cycle (gnt=0) between any two grants.
//  gnt is always exactly one-hot or zero; gnt == (gnt_valid ? 1<<gnt_idx : 0) every cycle.
//  Simultaneous requests: rotation order strictly relative to last; wrap 3->0.
//  Request glitch in IDLE (1 cycle) still wins if sampled; requester may then drop -> 1-cycle grant.
//  rst_n asserted mid-grant: outputs clear immediately (asynchronous), priority back to req[0].
//  rst_n deassertion is synchronised upstream; block assumes clean release.
// CONFIGURATION
//  Macro ARB_TIMEOUT_EN defined:
//   hold_cnt clears on entering BUSY, increments each BUSY cycle the owner's req stays high.
//   Reaching HOLD_MAX with req still high: next cycle forced release (gnt=0, IDLE),
//   timeout=1 for that one cycle, last=owner -> owner becomes lowest priority.
//   Owner may re-request; wins again only if no other req set.
//  Macro undefined: no counter, grant held indefinitely, timeout tied 0.
// STRUCTURE
//  Package rr_arb_pkg: typedef state_t {IDLE, BUSY}; localparam N_REQ=4, IDX_W=2.
//  Sub-module onehot_dec2to4 (2-bit index -> 4-bit one-hot, combinational);
//   instantiated on next-state index so that gnt is registered from its output.
//  Priority search: combinational rotate-and-find-first in top module.
// TESTING
//  1 reset, req=4'b1111 -> gnt=0001/idx 0 one clk later; drop req[0] -> gap, then 0010.
//  2 req=1111 held, each owner drops after 3 cycles -> grant order 0,1,2,3,0 with 1-cycle gaps.
//  3 last=2, req=4'b0011 -> grant idx 0 (wrap); req=4'b1000 only -> idx 3.
//  4 owner 1 holds, req[3] asserted meanwhile -> gnt stays 0010 until req[1] drops.
//  5 ARB_TIMEOUT_EN, HOLD_MAX=15, req[2] held 40 cycles, others 0 -> timeout pulse, re-grant idx 2.
//  6 rst_n low mid-BUSY (async, between edges) -> gnt=0 same instant; after release, req=1111 -> idx 0.

Source files
------------

// File: rtl/rr_decode_arbiter_pkg.sv
// Shared types for the round-robin decode arbiter: FSM state, requester
// count and grant-index width.
package rr_arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [N_REQ-1:0] req_t;

endpackage

// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_decode_arbiter_if;
  import rr_arb_pkg::*;

  req_t req;
  req_t gnt;
  idx_t gnt_idx;
  logic gnt_valid;
  logic timeout;

  modport master (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );

endinterface

// File: rtl/rr_decode_arbiter_onehot_dec2to4.sv
// Combinational 2-bit index to 4-bit one-hot decoder.
module onehot_dec2to4
  import rr_arb_pkg::*;
(
  input  idx_t idx_i,
  output req_t onehot_o
);

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_dec
    assign onehot_o[gi] = (idx_i == idx_t'(gi));
  end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for one shared 4-way select resource; grant held while owner requests.
// Optional forced release after HOLD_MAX busy cycles when ARB_TIMEOUT_EN is defined.
module rr_decode_arbiter
  import rr_arb_pkg::*;
#(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input logic               clk,
  input logic               rst_n,
  rr_decode_arbiter_if.slave arb
);

  state_t state_q, state_d;
  idx_t   last_q, last_d;
  idx_t   gnt_idx_q, gnt_idx_d;
  logic   gnt_valid_q, gnt_valid_d;
  req_t   gnt_q, gnt_d, dec_gnt;

  idx_t   start;
  req_t   rot;
  idx_t   offset;
  idx_t   win_idx;
  logic   owner_req;
  logic   force_rel;

  // Inconsistent counter sizing shows up as this named scope in the hierarchy.
  if (HOLD_MAX < 1 || HOLD_MAX > (1 << CNT_W) - 1) begin : g_hold_max_exceeds_cnt_w
  end

  // Rotate requests so that bit 0 is the requester just after the last owner.
  assign start = last_q + idx_t'(1);

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    assign rot[gi] = arb.req[start + idx_t'(gi)];
  end

  always_comb begin
    offset = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) offset = idx_t'(k);
    end
  end

  assign win_idx   = start + offset;
  assign owner_req = arb.req[gnt_idx_q];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;

  assign force_rel = owner_req && (hold_cnt_q == CNT_W'(HOLD_MAX - 1));
`else
  assign force_rel = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= idx_t'(N_REQ - 1);
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      gnt_q       <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_q       <= gnt_d;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q  <= hold_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = '0;
`endif
    case (state_q)
      IDLE: begin
        if (|arb.req) state_d = BUSY;
      end
      BUSY: begin
        if (!owner_req || force_rel) begin
          state_d = IDLE;
          last_d  = gnt_idx_q;
        end
`ifdef ARB_TIMEOUT_EN
        else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_idx_d   = '0;
    gnt_valid_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    timeout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|arb.req) begin
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
        end
      end
      BUSY: begin
        if (owner_req && !force_rel) begin
          gnt_idx_d   = gnt_idx_q;
          gnt_valid_d = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        timeout_d = force_rel;
`endif
      end
      default: ;
    endcase
  end

  // Decode the next-state index so the one-hot grant leaves a flop directly.
  onehot_dec2to4 u_dec (
    .idx_i    (gnt_idx_d),
    .onehot_o (dec_gnt)
  );

  assign gnt_d = gnt_valid_d ? dec_gnt : '0;

  assign arb.gnt       = gnt_q;
  assign arb.gnt_idx   = gnt_idx_q;
  assign arb.gnt_valid = gnt_valid_q;
`ifdef ARB_TIMEOUT_EN
  assign arb.timeout   = timeout_q;
`else
  assign arb.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed self-checking bench for rr_decode_arbiter (timeout checks follow ARB_TIMEOUT_EN).
module tb_rr_decode_arbiter;
  import rr_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  rr_decode_arbiter_if arb_if ();

  rr_decode_arbiter #(
    .HOLD_MAX (15),
    .CNT_W    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (arb_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_grant(input string tag, input logic [3:0] exp_gnt, input logic exp_to);
    logic [1:0] exp_idx;
    exp_idx = 2'd0;
    for (int i = 0; i < 4; i++) if (exp_gnt[i]) exp_idx = 2'(i);
    chk({tag, " gnt"}, 8'(arb_if.gnt), 8'(exp_gnt));
    chk({tag, " gnt_valid"}, 8'(arb_if.gnt_valid), 8'(exp_gnt != 4'b0000));
    chk({tag, " timeout"}, 8'(arb_if.timeout), 8'(exp_to));
    if (exp_gnt != 4'b0000) chk({tag, " gnt_idx"}, 8'(arb_if.gnt_idx), 8'(exp_idx));
    $display("t=%0t %s req=%b gnt=%b idx=%0d valid=%b timeout=%b", $time, tag,
             arb_if.req, arb_if.gnt, arb_if.gnt_idx, arb_if.gnt_valid, arb_if.timeout);
  endtask

  initial begin
    rst_n      = 1'b0;
    arb_if.req = 4'b0000;
    tick();
    chk_grant("reset", 4'b0000, 1'b0);

    // 1: all request, req[0] first; drop it -> gap then requester 1
    rst_n      = 1'b1;
    arb_if.req = 4'b1111;
    tick(); chk_grant("t1 first grant", 4'b0001, 1'b0);
    arb_if.req = 4'b1110;
    tick(); chk_grant("t1 gap", 4'b0000, 1'b0);
    tick(); chk_grant("t1 second grant", 4'b0010, 1'b0);

    // 4: owner 1 holds while req[3] rises
    arb_if.req = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      tick(); chk_grant("t4 hold owner1", 4'b0010, 1'b0);
    end
    arb_if.req = 4'b1000;
    tick(); chk_grant("t4 release", 4'b0000, 1'b0);
    tick(); chk_grant("t4 req3 only", 4'b1000, 1'b0);
    arb_if.req = 4'b0000;
    tick(); chk_grant("t4 release3", 4'b0000, 1'b0);
    tick(); chk_grant("t4 idle", 4'b0000, 1'b0);

    // 2: all held, each owner drops after 3 grant cycles -> 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (k % 4);
      arb_if.req = 4'b1111;
      tick(); chk_grant("t2 grant", oh, 1'b0);
      tick(); chk_grant("t2 hold", oh, 1'b0);
      tick(); chk_grant("t2 hold", oh, 1'b0);
      arb_if.req = 4'b1111 & ~oh;
      tick(); chk_grant("t2 gap", 4'b0000, 1'b0);
    end
    arb_if.req = 4'b0000;
    tick(); chk_grant("t2 idle", 4'b0000, 1'b0);

    // 3: make last=2, then 0011 must wrap to requester 0
    arb_if.req = 4'b0100;
    tick(); chk_grant("t3 grant2", 4'b0100, 1'b0);
    arb_if.req = 4'b0000;
    tick(); chk_grant("t3 release2", 4'b0000, 1'b0);
    arb_if.req = 4'b0011;
    tick(); chk_grant("t3 wrap to 0", 4'b0001, 1'b0);
    arb_if.req = 4'b0000;
    tick(); chk_grant("t3 release0", 4'b0000, 1'b0);

    // one-cycle request glitch still wins, giving a one-cycle grant
    arb_if.req = 4'b0100;
    tick(); chk_grant("glitch grant", 4'b0100, 1'b0);
    arb_if.req = 4'b0000;
    tick(); chk_grant("glitch release", 4'b0000, 1'b0);

    // 5: req[2] held 40 cycles, others idle
    arb_if.req = 4'b0100;
    for (int t = 1; t <= 40; t++) begin
      tick();
`ifdef ARB_TIMEOUT_EN
      if (t % 16 == 0) chk_grant("t5 forced release", 4'b0000, 1'b1);
      else             chk_grant("t5 hold", 4'b0100, 1'b0);
`else
      chk_grant("t5 hold", 4'b0100, 1'b0);
`endif
    end
    arb_if.req = 4'b0000;
    tick(); chk_grant("t5 release", 4'b0000, 1'b0);

    // 6: asynchronous reset in the middle of a grant
    arb_if.req = 4'b1000;
    tick(); chk_grant("t6 grant3", 4'b1000, 1'b0);
    #3 rst_n = 1'b0;
    #1 chk_grant("t6 async clear", 4'b0000, 1'b0);
    tick(); chk_grant("t6 held in reset", 4'b0000, 1'b0);
    rst_n      = 1'b1;
    arb_if.req = 4'b1111;
    tick(); chk_grant("t6 priority back to 0", 4'b0001, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
